// File: rtl/reg_32_shift_ctrl_if.sv
// Job request channel of the shift-register sequencer: one job per valid/ready handshake.
// The requester drives the master side and the sequencer owns the slave side.
interface reg_32_shift_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 6
);
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [WIDTH-1:0] REQ_DATA;
  logic [LEN_W-1:0] REQ_LEN;
  logic             REQ_DIR;
  logic             REQ_ROT;
  logic             REQ_SIN;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_LEN, REQ_DIR, REQ_ROT, REQ_SIN,
    input  REQ_READY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_LEN, REQ_DIR, REQ_ROT, REQ_SIN,
    output REQ_READY
  );
endinterface

// File: rtl/reg_32_shift_ctrl.sv
// Sequencer for the 32-bit universal shift register: load a job word, shift/rotate it LEN
// times, then capture Q into RESULT. Optional ABORT/ABORTED ports under REG_32_SHIFT_CTRL_ABORT_EN.
module reg_32_shift_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 6
) (
  input  logic              CLK,
  input  logic              RST_L,
  reg_32_shift_ctrl_if.slave req,
`ifdef REG_32_SHIFT_CTRL_ABORT_EN
  input  logic              ABORT,
  output logic              ABORTED,
`endif
  output logic              ENB,
  output logic              DIR,
  output logic              S_IN,
  output logic [1:0]        MODO,
  output logic [WIDTH-1:0]  D,
  input  logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  RESULT,
  output logic              DONE,
  output logic              BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPT,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_result;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_rot;
  logic             r_sin;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_accept;
  logic             w_abort;

`ifdef REG_32_SHIFT_CTRL_ABORT_EN
  logic r_aborted;
  assign w_abort = ABORT;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept      = (r_state == S_IDLE) && req.REQ_VALID;
  assign w_len_clamped = (req.REQ_LEN > LP_MAX_LEN) ? LP_MAX_LEN : req.REQ_LEN;

  assign D      = r_data;
  assign DIR    = r_dir;
  assign S_IN   = r_sin;
  assign RESULT = r_result;

  always_comb begin
    w_next        = r_state;
    ENB           = 1'b0;
    MODO          = 2'b11;
    req.REQ_READY = 1'b0;
    DONE          = 1'b0;
    BUSY          = 1'b1;
    case (r_state)
      S_IDLE: begin
        req.REQ_READY = 1'b1;
        BUSY          = 1'b0;
        if (req.REQ_VALID) w_next = S_LOAD;
      end
      S_LOAD: begin
        ENB  = 1'b1;
        MODO = 2'b10;
        if (w_abort || (r_len == '0)) w_next = S_CAPT;
        else                          w_next = S_SHIFT;
      end
      S_SHIFT: begin
        ENB  = 1'b1;
        MODO = {1'b0, r_rot};
        if (w_abort || (r_cnt == '0)) w_next = S_CAPT;
      end
      S_CAPT:  w_next = S_DONE;
      S_DONE: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_cnt holds the number of SHIFT cycles still to run after the current one.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_result <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_rot    <= 1'b0;
      r_sin    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data <= req.REQ_DATA;
        r_len  <= w_len_clamped;
        r_dir  <= req.REQ_DIR;
        r_rot  <= req.REQ_ROT;
        r_sin  <= req.REQ_SIN;
      end
      if (r_state == S_LOAD) r_cnt <= r_len - LEN_W'(1);
      if ((r_state == S_SHIFT) && (r_cnt != '0)) r_cnt <= r_cnt - LEN_W'(1);
      if (r_state == S_CAPT) r_result <= Q;
    end
  end

`ifdef REG_32_SHIFT_CTRL_ABORT_EN
  // Flag survives until DONE so ABORTED pulses together with DONE.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_aborted <= 1'b0;
    end else if (w_accept) begin
      r_aborted <= 1'b0;
    end else if (((r_state == S_LOAD) || (r_state == S_SHIFT)) && w_abort) begin
      r_aborted <= 1'b1;
    end
  end

  assign ABORTED = (r_state == S_DONE) && r_aborted;
`endif

endmodule
